// File: rtl/qpll_reset_ctrl.sv
// Power-up, reset and lock supervisor for one GTXE2_COMMON QPLL quad.
// Optional lock filter stage enabled by defining QPLL_LOCK_FILTER_EN.
module qpll_reset_ctrl #(
    parameter int PD_CYCLES          = 16,
    parameter int RESET_CYCLES       = 16,
    parameter int LOCK_TIMEOUT       = 65535,
    parameter int MAX_RETRIES        = 3,
    parameter int LOCK_STABLE_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       qpll_lock_i,
    input  logic       qpll_refclklost_i,
    output logic       qpll_pd_o,
    output logic       qpll_reset_o,
    output logic       qpll_ready_o,
    output logic       fail_o,
    output logic [7:0] retry_cnt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PD        = 3'd1,
        S_RESET     = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_LOCKED    = 3'd4,
        S_FAIL      = 3'd5
`ifdef QPLL_LOCK_FILTER_EN
        , S_LOCK_FILT = 3'd6
`endif
    } state_e;

    localparam int PH_MAX = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PH_W-1:0]  PD_LAST   = PH_W'(PD_CYCLES - 1);
    localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_SAT    = PH_W'(PH_MAX);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_SAT   = TMO_W'(LOCK_TIMEOUT);
    localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

    if (PD_CYCLES < 1 || RESET_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
        MAX_RETRIES < 0 || MAX_RETRIES > 255 || LOCK_STABLE_CYCLES < 1) begin : g_param_check
        $error("qpll_reset_ctrl: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       retry_q, retry_d;
    logic             pd_q, qrst_q, ready_q, fail_q;
    logic             lock_meta_q, lock_s_q, lost_meta_q, lost_s_q;
    logic             good, timeout_hit;

`ifdef QPLL_LOCK_FILTER_EN
    localparam int FILT_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_SAT  = FILT_W'(LOCK_STABLE_CYCLES);
    logic [FILT_W-1:0] filt_q, filt_d;
`endif

    assign good = lock_s_q & ~lost_s_q;

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        timeout_hit = 1'b0;
`ifdef QPLL_LOCK_FILTER_EN
        filt_d      = filt_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_PD;
            S_PD: begin
                ph_d = (ph_q == PH_SAT) ? ph_q : ph_q + PH_W'(1);
                if (ph_q == PD_LAST) state_d = S_RESET;
            end
            S_RESET: begin
                ph_d = (ph_q == PH_SAT) ? ph_q : ph_q + PH_W'(1);
                if (ph_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                tmo_d = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
`ifdef QPLL_LOCK_FILTER_EN
                if (good) state_d = S_LOCK_FILT;
`else
                if (good) state_d = S_LOCKED;
`endif
                else if (tmo_q == TMO_LAST) timeout_hit = 1'b1;
            end
`ifdef QPLL_LOCK_FILTER_EN
            S_LOCK_FILT: begin
                tmo_d  = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + TMO_W'(1);
                filt_d = (filt_q == FILT_SAT) ? filt_q : filt_q + FILT_W'(1);
                if (good && filt_q == FILT_LAST) state_d = S_LOCKED;
                else if (tmo_q == TMO_LAST)      timeout_hit = 1'b1;
                else if (!good)                  state_d = S_WAIT_LOCK;
            end
`endif
            S_LOCKED: begin
                if (!good) begin
                    state_d = S_RESET;
                    retry_d = 8'd0;
                end
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_IDLE;
        endcase

        if (timeout_hit) begin
            if (retry_q == RETRY_MAX) begin
                state_d = S_FAIL;
            end else begin
                retry_d = retry_q + 8'd1;
                state_d = S_RESET;
            end
        end

        // Every state entry restarts its counters; the timeout spans WAIT_LOCK and LOCK_FILT.
        if (state_d != state_q) begin
            ph_d = '0;
`ifdef QPLL_LOCK_FILTER_EN
            filt_d = '0;
            if (!((state_q == S_WAIT_LOCK || state_q == S_LOCK_FILT) &&
                  (state_d == S_WAIT_LOCK || state_d == S_LOCK_FILT))) tmo_d = '0;
`else
            tmo_d = '0;
`endif
        end

        if (!enable_i) begin
            state_d = S_IDLE;
            retry_d = 8'd0;
            ph_d    = '0;
            tmo_d   = '0;
`ifdef QPLL_LOCK_FILTER_EN
            filt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            tmo_q       <= '0;
            retry_q     <= 8'd0;
            pd_q        <= 1'b1;
            qrst_q      <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            lost_meta_q <= 1'b0;
            lost_s_q    <= 1'b0;
`ifdef QPLL_LOCK_FILTER_EN
            filt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            pd_q        <= (state_d == S_IDLE) || (state_d == S_PD) || (state_d == S_FAIL);
            qrst_q      <= (state_d == S_IDLE) || (state_d == S_PD) ||
                           (state_d == S_RESET) || (state_d == S_FAIL);
            ready_q     <= (state_d == S_LOCKED);
            fail_q      <= (state_d == S_FAIL);
            lock_meta_q <= qpll_lock_i;
            lock_s_q    <= lock_meta_q;
            lost_meta_q <= qpll_refclklost_i;
            lost_s_q    <= lost_meta_q;
`ifdef QPLL_LOCK_FILTER_EN
            filt_q      <= filt_d;
`endif
        end
    end

    assign qpll_pd_o    = pd_q;
    assign qpll_reset_o = qrst_q;
    assign qpll_ready_o = ready_q;
    assign fail_o       = fail_q;
    assign retry_cnt_o  = retry_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_qpll_reset_ctrl.sv
// Directed self-checking bench for qpll_reset_ctrl (PD=4, RESET=4, TIMEOUT=20, RETRIES=2).
module tb_qpll_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_i;
    logic       qpll_lock_i;
    logic       qpll_refclklost_i;
    logic       qpll_pd_o;
    logic       qpll_reset_o;
    logic       qpll_ready_o;
    logic       fail_o;
    logic [7:0] retry_cnt_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

`ifdef QPLL_LOCK_FILTER_EN
    localparam int FE = 8;
`else
    localparam int FE = 0;
`endif

    qpll_reset_ctrl #(
        .PD_CYCLES(4),
        .RESET_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .MAX_RETRIES(2),
        .LOCK_STABLE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_i(enable_i),
        .qpll_lock_i(qpll_lock_i),
        .qpll_refclklost_i(qpll_refclklost_i),
        .qpll_pd_o(qpll_pd_o),
        .qpll_reset_o(qpll_reset_o),
        .qpll_ready_o(qpll_ready_o),
        .fail_o(fail_o),
        .retry_cnt_o(retry_cnt_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int st, input int pd, input int rs,
                             input int rdy, input int fl, input int rc);
        check({tag, ".state"}, int'(state_o), st);
        check({tag, ".pd"}, int'(qpll_pd_o), pd);
        check({tag, ".reset"}, int'(qpll_reset_o), rs);
        check({tag, ".ready"}, int'(qpll_ready_o), rdy);
        check({tag, ".fail"}, int'(fail_o), fl);
        check({tag, ".retry"}, int'(retry_cnt_o), rc);
    endtask

    initial begin
        rst = 1'b1;
        enable_i = 1'b1;
        qpll_lock_i = 1'b0;
        qpll_refclklost_i = 1'b0;

        // Cold start
        step(3);
        check_all("rst", 0, 1, 1, 0, 0, 0);
        rst = 1'b0;
        step(1);
        check_all("pd_first", 1, 1, 1, 0, 0, 0);
        step(3);
        check_all("pd_last", 1, 1, 1, 0, 0, 0);
        step(1);
        check_all("rst_first", 2, 0, 1, 0, 0, 0);
        step(3);
        check_all("rst_last", 2, 0, 1, 0, 0, 0);
        step(1);
        check_all("wait_first", 3, 0, 0, 0, 0, 0);
        step(4);
        qpll_lock_i = 1'b1;
        step(2 + FE);
        check("cold_pre_ready", int'(qpll_ready_o), 0);
        step(1);
        check_all("cold_locked", 4, 0, 0, 1, 0, 0);

        // Timeouts to the sticky failure state
        enable_i = 1'b0;
        qpll_lock_i = 1'b0;
        step(1);
        check_all("disable", 0, 1, 1, 0, 0, 0);
        step(2);
        enable_i = 1'b1;
        step(9);
        check_all("to_wait0", 3, 0, 0, 0, 0, 0);
        step(19);
        check_all("to_wait0_end", 3, 0, 0, 0, 0, 0);
        step(1);
        check_all("to_retry1", 2, 0, 1, 0, 0, 1);
        step(3);
        check("to_retry1_rst", int'(state_o), 2);
        step(1);
        check_all("to_wait1", 3, 0, 0, 0, 0, 1);
        step(19);
        check("to_wait1_end", int'(state_o), 3);
        step(1);
        check_all("to_retry2", 2, 0, 1, 0, 0, 2);
        step(4);
        check_all("to_wait2", 3, 0, 0, 0, 0, 2);
        step(19);
        check("to_wait2_end", int'(state_o), 3);
        step(1);
        check_all("to_fail", 5, 1, 1, 0, 1, 2);
        step(5);
        check_all("fail_sticky", 5, 1, 1, 0, 1, 2);
        enable_i = 1'b0;
        step(1);
        check_all("fail_exit", 0, 1, 1, 0, 0, 0);
        step(3);
        check_all("idle_hold", 0, 1, 1, 0, 0, 0);

        // Relock after refclk loss, starting from retry_cnt 1
        enable_i = 1'b1;
        step(9);
        step(20);
        check_all("rl_retry1", 2, 0, 1, 0, 0, 1);
        step(4);
        check("rl_wait", int'(state_o), 3);
        qpll_lock_i = 1'b1;
        step(3 + FE);
        check_all("rl_locked", 4, 0, 0, 1, 0, 1);
        qpll_refclklost_i = 1'b1;
        step(1);
        qpll_refclklost_i = 1'b0;
        step(1);
        check_all("rl_still_locked", 4, 0, 0, 1, 0, 1);
        step(1);
        check_all("rl_drop", 2, 0, 1, 0, 0, 0);
        step(3);
        check("rl_rst_last", int'(qpll_reset_o), 1);
        step(1);
        check_all("rl_wait2", 3, 0, 0, 0, 0, 0);
        step(1 + FE);
        check_all("rl_relocked", 4, 0, 0, 1, 0, 0);

`ifndef QPLL_LOCK_FILTER_EN
        // Lock qualifies on the same cycle the timeout expires
        enable_i = 1'b0;
        qpll_lock_i = 1'b0;
        step(3);
        enable_i = 1'b1;
        step(9);
        step(20);
        step(4);
        check_all("race_wait", 3, 0, 0, 0, 0, 1);
        step(17);
        qpll_lock_i = 1'b1;
        step(1);
        check("race_s18", int'(state_o), 3);
        step(1);
        check("race_s19", int'(state_o), 3);
        step(1);
        check_all("race_locked", 4, 0, 0, 1, 0, 1);
`endif

        // Aborts
        enable_i = 1'b0;
        qpll_lock_i = 1'b0;
        step(3);
        enable_i = 1'b1;
        step(6);
        check("ab_mid_reset", int'(state_o), 2);
        enable_i = 1'b0;
        step(1);
        check_all("ab_reset_idle", 0, 1, 1, 0, 0, 0);
        enable_i = 1'b1;
        step(14);
        check("ab_mid_wait", int'(state_o), 3);
        enable_i = 1'b0;
        step(1);
        check_all("ab_wait_idle", 0, 1, 1, 0, 0, 0);
        enable_i = 1'b1;
        qpll_lock_i = 1'b1;
        step(10 + FE);
        check_all("ab_locked", 4, 0, 0, 1, 0, 0);
        rst = 1'b1;
        step(1);
        check_all("ab_rst_locked", 0, 1, 1, 0, 0, 0);
        rst = 1'b0;

`ifdef QPLL_LOCK_FILTER_EN
        // Lock filter: short glitch is rejected, stable lock qualifies
        qpll_lock_i = 1'b0;
        enable_i = 1'b0;
        step(3);
        enable_i = 1'b1;
        step(9);
        check("flt_wait", int'(state_o), 3);
        qpll_lock_i = 1'b1;
        step(5);
        qpll_lock_i = 1'b0;
        check_all("flt_glitch", 6, 0, 0, 0, 0, 0);
        step(3);
        check_all("flt_back", 3, 0, 0, 0, 0, 0);
        qpll_lock_i = 1'b1;
        step(3);
        check("flt_enter", int'(state_o), 6);
        step(7);
        check_all("flt_hold", 6, 0, 0, 0, 0, 0);
        step(1);
        check_all("flt_locked", 4, 0, 0, 1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qpll_reset_ctrl.md
Name: qpll_reset_ctrl

Overview:
- Power-up, reset and lock supervisor for one GTXE2_COMMON QPLL quad.
- Sequences QPLLPD/QPLLRESET, waits for QPLLLOCK with timeout and bounded retry, monitors lock and refclk loss, and automatically re-locks.
- Sits between the PHY top-level enable and the QPLL primitive; its qpll_ready_o gates the channel reset sequencers.

Parameters:
- PD_CYCLES, 16: cycles qpll_pd_o is held high on cold start (>=1).
- RESET_CYCLES, 16: cycles qpll_reset_o is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before an attempt fails (>=1).
- MAX_RETRIES, 3: extra reset attempts after the first timeout before FAIL (0..255).
- LOCK_STABLE_CYCLES, 256: lock filter length; used only with the optional feature.

Ports:
- clk  in  1  free-running system clock; also drives QPLLLOCKDETCLK.
- rst  in  1  synchronous, active-high reset.
- enable_i  in  1  level; 1 = bring up the QPLL, 0 = hold it powered down.
- qpll_lock_i  in  1  QPLLLOCK; asynchronous to clk.
- qpll_refclklost_i  in  1  QPLLREFCLKLOST; asynchronous to clk.
- qpll_pd_o  out  1  to QPLLPD.
- qpll_reset_o  out  1  to QPLLRESET.
- qpll_ready_o  out  1  QPLL locked and stable.
- fail_o  out  1  retries exhausted.
- retry_cnt_o  out  8  timeouts in the current bring-up.
- state_o  out  3  encoding: IDLE=0, PD=1, RESET=2, WAIT_LOCK=3, LOCKED=4, FAIL=5.

Behaviour:
- Reset and outputs:
  - Reset values: state IDLE, qpll_pd_o=1, qpll_reset_o=1, qpll_ready_o=0, fail_o=0, retry_cnt_o=0, all counters 0.
  - All outputs are registered.
- Synchronisers:
  - qpll_lock_i and qpll_refclklost_i each pass through a 2-flop synchroniser (lock_s, lost_s), cleared by rst.
  - Input-to-decision latency is 2 cycles.
- good = lock_s & ~lost_s.
- Priority: rst > enable_i=0 > all other transitions. enable_i=0 in any state forces IDLE on the next edge with pd=1, reset=1, ready=0, fail=0, retry_cnt cleared, counters cleared.
- IDLE: pd=1, reset=1. enable_i=1 -> PD.
- PD: pd=1, reset=1 for exactly PD_CYCLES cycles -> RESET.
- RESET: pd=0, reset=1 for exactly RESET_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK:
  - pd=0, reset=0. The timeout counter increments each cycle.
  - good=1 -> LOCKED, with ready=1 on the entry cycle. This takes priority over a timeout in the same cycle.
  - Counter reaches LOCK_TIMEOUT-1 without good:
    - If retry_cnt==MAX_RETRIES -> FAIL.
    - Otherwise retry_cnt+=1 -> RESET. PD is not repeated.
- LOCKED:
  - pd=0, reset=0, ready=1. retry_cnt holds its value.
  - good=0 -> RESET, with ready=0 on that edge and retry_cnt cleared to 0 (fresh relock budget).
- FAIL: pd=1, reset=1, ready=0, fail=1. Sticky; the only exit is enable_i=0 (or rst).
- Counters:
  - Each counter is $clog2(max+1) bits and saturates; none wraps.
  - Counters are cleared on every state entry.
- Mid-sequence events:
  - Lock asserting during PD or RESET is ignored.
  - lost_s during WAIT_LOCK blocks good, so the timeout keeps running.

Optional Feature:
- Macro: QPLL_LOCK_FILTER_EN.
- Defined: adds state LOCK_FILT=6 between WAIT_LOCK and LOCKED.
  - WAIT_LOCK with good=1 -> LOCK_FILT, where pd=0, reset=0, ready=0.
  - good held for LOCK_STABLE_CYCLES consecutive cycles -> LOCKED.
  - good dropping in LOCK_FILT returns to WAIT_LOCK without clearing the timeout counter.
  - The timeout keeps counting in LOCK_FILT, and expiry there follows the WAIT_LOCK rules.
- Undefined: the LOCK_FILT state and its counter are absent, LOCK_STABLE_CYCLES is unused, and WAIT_LOCK goes directly to LOCKED.

Test Plan:
- Common parameters for the directed tests: PD_CYCLES=4, RESET_CYCLES=4, LOCK_TIMEOUT=20, MAX_RETRIES=2.
- Cold start: rst 3 cycles, enable_i=1 at cycle 0.
  - pd=1 through the end of PD, then 4 cycles of reset=1 with pd=0, then reset=0.
  - lock_i raised 5 cycles into WAIT_LOCK -> ready=1 exactly 3 cycles after the lock edge; state_o=4; retry_cnt_o=0.
- Timeouts to FAIL: lock_i held 0.
  - Three WAIT_LOCK periods of 20 cycles each, separated by 4-cycle reset pulses with no PD.
  - retry_cnt_o steps 1, 2; then fail_o=1, state_o=5, pd=1.
  - Drop enable_i -> IDLE, fail_o=0, retry_cnt_o=0.
- Relock: in LOCKED with retry_cnt_o=1, pulse qpll_refclklost_i for 1 cycle.
  - ready drops 3 cycles later; retry_cnt_o=0; a 4-cycle reset pulse follows; lock held -> ready reasserts.
- Race: lock_s rising on the same cycle the timeout expires -> LOCKED, retry_cnt_o unchanged.
- Abort: deassert enable_i mid-RESET and mid-WAIT_LOCK -> next cycle state_o=0, pd=1, reset=1; rst asserted mid-LOCKED gives the same result.
- Filter (QPLL_LOCK_FILTER_EN, LOCK_STABLE_CYCLES=8):
  - lock glitches high for 5 cycles -> no ready; state returns to 3.
  - Lock stable -> ready 8 cycles after entering LOCK_FILT.
